// File: rtl/bounce_gen.sv
// ---------------------------------------------------------------------------
// bounce_gen - switch-bounce emulator.
//
// Turns a clean synchronous level into a noisy switch waveform. Each change of
// clean_in starts a bounce window of BOUNCE_CYCLES clocks. Inside the window,
// noisy_out toggles at pseudo-random intervals of
// MIN_GLITCH + lfsr[GLITCH_BITS-1:0] cycles. When the window ends, noisy_out is
// forced to the commanded level. The LFSR is seeded, so a given seed and
// stimulus always produce the same waveform.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   clean_in     in   clean commanded level, synchronous to clock
//   noisy_out    out  emulated bouncing level (registered)
//   busy         out  high while a bounce window is active (registered)
//   bounce_count out  [7:0] toggles in the current/last event; present only
//                     when BOUNCE_GEN_STATS_EN is defined
//
// Optional feature macro: BOUNCE_GEN_STATS_EN (adds bounce_count).
// ---------------------------------------------------------------------------
module bounce_gen #(
    parameter int          BOUNCE_CYCLES = 2000,
    parameter int          MIN_GLITCH    = 8,
    parameter int          GLITCH_BITS   = 4,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clean_in,
    output logic       noisy_out,
`ifdef BOUNCE_GEN_STATS_EN
    output logic [7:0] bounce_count,
`endif
    output logic       busy
);

    // An all-zero seed would lock the LFSR, so substitute the default seed.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [19:0] WIN_LAST = 20'(BOUNCE_CYCLES - 1);
    localparam logic [8:0]  MIN_SEG  = 9'(MIN_GLITCH);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_BOUNCE = 1'b1
    } state_t;

    // One step of the 16-bit right-shifting Galois LFSR, taps 0xB400.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? 16'hB400 : 16'h0000);
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic        noisy_r;
    logic        target_r;
    logic        busy_r;
    logic [19:0] window_r;
    logic [8:0]  seg_r;
    logic [15:0] lfsr_r;

    logic        noisy_next_s;
    logic        target_next_s;
    logic [19:0] window_next_s;
    logic [8:0]  seg_next_s;
    logic        change_s;
    logic        win_last_s;
    logic [8:0]  seg_load_s;

    assign change_s   = (clean_in != target_r);
    assign win_last_s = (window_r == WIN_LAST);
    assign seg_load_s = MIN_SEG + 9'(lfsr_r[GLITCH_BITS-1:0]);

    // State and datapath registers; reset takes priority over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            noisy_r  <= clean_in;
            target_r <= clean_in;
            busy_r   <= 1'b0;
            window_r <= 20'd0;
            seg_r    <= 9'd0;
            lfsr_r   <= SEED_EFF;
        end else begin
            state_r  <= state_next_s;
            noisy_r  <= noisy_next_s;
            target_r <= target_next_s;
            busy_r   <= (state_next_s == ST_BOUNCE);
            window_r <= window_next_s;
            seg_r    <= seg_next_s;
            lfsr_r   <= lfsr_step(lfsr_r);
        end
    end

    // Next-state logic: a level change always (re)opens the window.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (change_s) begin
                    state_next_s = ST_BOUNCE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_BOUNCE: begin
                if (change_s) begin
                    state_next_s = ST_BOUNCE;
                end else if (win_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BOUNCE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath next values: toggles, segment reloads and the final settle.
    always_comb begin
        noisy_next_s  = noisy_r;
        target_next_s = target_r;
        window_next_s = window_r;
        seg_next_s    = seg_r;
        case (state_r)
            ST_IDLE: begin
                if (change_s) begin
                    target_next_s = clean_in;
                    noisy_next_s  = ~noisy_r;
                    window_next_s = 20'd0;
                    seg_next_s    = seg_load_s;
                end else begin
                    noisy_next_s  = target_r;
                end
            end
            ST_BOUNCE: begin
                if (change_s) begin
                    // Retrigger: restart the window, leave noisy_out alone.
                    target_next_s = clean_in;
                    window_next_s = 20'd0;
                    seg_next_s    = seg_load_s;
                end else if (win_last_s) begin
                    // Settle wins over a coincident segment expiry, which
                    // also makes toggle parity irrelevant.
                    noisy_next_s  = target_r;
                    window_next_s = 20'd0;
                    seg_next_s    = 9'd0;
                end else if (seg_r == 9'd1) begin
                    noisy_next_s  = ~noisy_r;
                    window_next_s = window_r + 20'd1;
                    seg_next_s    = seg_load_s;
                end else begin
                    window_next_s = window_r + 20'd1;
                    seg_next_s    = seg_r - 9'd1;
                end
            end
            default: begin
                noisy_next_s = target_r;
            end
        endcase
    end

`ifdef BOUNCE_GEN_STATS_EN
    logic [7:0] count_r;
    logic       toggle_s;

    // A toggle is any level change made while bouncing and not retriggered.
    always_comb begin
        if ((state_r == ST_BOUNCE) && !change_s) begin
            toggle_s = (noisy_next_s != noisy_r);
        end else begin
            toggle_s = 1'b0;
        end
    end

    // Per-event toggle counter; starts at 1 for the entry toggle, saturates.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (change_s) begin
            count_r <= 8'd1;
        end else if (toggle_s && (count_r != 8'd255)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign bounce_count = count_r;
`endif

    assign noisy_out = noisy_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_bounce_gen.sv
// ---------------------------------------------------------------------------
// tb_bounce_gen - self-checking bench for bounce_gen.
// Two instances share the stimulus: one with SEED=16'hACE1 and one with SEED=0.
// Both must follow the same event-level reference model, which tracks absolute
// settle and toggle times instead of counters.
// ---------------------------------------------------------------------------
module tb_bounce_gen;

    localparam int BC = 100;
    localparam int MG = 4;
    localparam int GB = 3;
    localparam int NRAND = 1500;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic clean_in = 1'b1;
    logic noisy_a, busy_a, noisy_z, busy_z;
`ifdef BOUNCE_GEN_STATS_EN
    logic [7:0] cnt_a, cnt_z;
`endif

    bounce_gen #(.BOUNCE_CYCLES(BC), .MIN_GLITCH(MG), .GLITCH_BITS(GB),
                 .SEED(16'hACE1)) dut_a (
        .clock(clock), .reset(reset), .clean_in(clean_in),
        .noisy_out(noisy_a),
`ifdef BOUNCE_GEN_STATS_EN
        .bounce_count(cnt_a),
`endif
        .busy(busy_a));

    bounce_gen #(.BOUNCE_CYCLES(BC), .MIN_GLITCH(MG), .GLITCH_BITS(GB),
                 .SEED(16'h0000)) dut_z (
        .clock(clock), .reset(reset), .clean_in(clean_in),
        .noisy_out(noisy_z),
`ifdef BOUNCE_GEN_STATS_EN
        .bounce_count(cnt_z),
`endif
        .busy(busy_z));

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Reference model state: absolute edge numbers of the next events.
    int m_lfsr;
    bit m_noisy, m_tgt, m_act;
    int m_settle, m_toggle, m_cnt;

    bit cin_q[NRAND];
    bit rst_q[NRAND];
    bit trace_q[NRAND];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s at cycle %0d: got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int seg_len(input int l);
        return MG + (l % (1 << GB));
    endfunction

    task automatic bump();
        if (m_cnt < 255) m_cnt++;
    endtask

    // Apply one clock edge to the model, using the inputs seen at that edge.
    task automatic model_step(input bit rst, input bit cin);
        if (rst) begin
            m_noisy = cin; m_tgt = cin; m_act = 0; m_cnt = 0;
            m_lfsr = 32'hACE1;
        end else begin
            if (cin != m_tgt) begin
                if (!m_act) m_noisy = !m_noisy;
                m_act = 1; m_tgt = cin; m_cnt = 1;
                m_settle = cyc + BC;
                m_toggle = cyc + seg_len(m_lfsr);
            end else if (m_act && cyc == m_settle) begin
                if (m_noisy != m_tgt) begin m_noisy = m_tgt; bump(); end
                m_act = 0;
            end else if (m_act && cyc == m_toggle) begin
                m_noisy = !m_noisy; bump();
                m_toggle = cyc + seg_len(m_lfsr);
            end
            m_lfsr = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 32'hB400 : 32'h0);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(reset, clean_in);
        cyc++;
        #1;
        chk("noisy_a", {31'd0, noisy_a}, {31'd0, m_noisy});
        chk("busy_a",  {31'd0, busy_a},  {31'd0, m_act});
        chk("noisy_z", {31'd0, noisy_z}, {31'd0, m_noisy});
        chk("busy_z",  {31'd0, busy_z},  {31'd0, m_act});
`ifdef BOUNCE_GEN_STATS_EN
        chk("count_a", {24'd0, cnt_a}, m_cnt);
        chk("count_z", {24'd0, cnt_z}, m_cnt);
`endif
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int last_t, gap;
        bit prev;
        int toggles;

        // Reset with clean_in high, then idle.
        reset = 1'b1; clean_in = 1'b1;
        ticks(2);
        chk("rst_noisy", {31'd0, noisy_a}, 32'd1);
        chk("rst_busy",  {31'd0, busy_a},  32'd0);
        reset = 1'b0;
        ticks(50);
        chk("idle_noisy", {31'd0, noisy_a}, 32'd1);

        // Falling edge: first toggle next edge, gaps in range, settle at +100.
        clean_in = 1'b0;
        tick();
        chk("edge_noisy", {31'd0, noisy_a}, 32'd0);
        chk("edge_busy",  {31'd0, busy_a},  32'd1);
        last_t = cyc; prev = noisy_a; toggles = 1;
        for (int k = 2; k <= 100; k++) begin
            tick();
            if (noisy_a != prev) begin
                gap = cyc - last_t;
                chk("gap_in_range", {31'd0, (gap >= MG && gap <= MG + 7)}, 32'd1);
                last_t = cyc; toggles++;
            end
            prev = noisy_a;
        end
        chk("pre_settle_busy", {31'd0, busy_a}, 32'd1);
        chk("burst_has_toggles", {31'd0, toggles >= 9}, 32'd1);
        tick();
        chk("settle_noisy", {31'd0, noisy_a}, 32'd0);
        chk("settle_busy",  {31'd0, busy_a},  32'd0);
        ticks(20);
        chk("stable_noisy", {31'd0, noisy_a}, 32'd0);

        // Retrigger 40 cycles into a burst.
        clean_in = 1'b1;
        tick();
        ticks(39);
        clean_in = 1'b0;
        tick();
        ticks(60);
        chk("no_early_settle", {31'd0, busy_a}, 32'd1);
        ticks(40);
        chk("retrig_noisy", {31'd0, noisy_a}, 32'd0);
        chk("retrig_busy",  {31'd0, busy_a},  32'd0);
        ticks(5);

        // Reset mid-bounce, then a normal burst.
        clean_in = 1'b1;
        tick();
        ticks(28);
        reset = 1'b1;
        tick();
        chk("midrst_noisy", {31'd0, noisy_a}, 32'd1);
        chk("midrst_busy",  {31'd0, busy_a},  32'd0);
        reset = 1'b0; clean_in = 1'b0;
        ticks(110);
        chk("post_rst_settle", {31'd0, busy_a}, 32'd0);

        // Random stimulus, including a toggle-every-cycle stretch.
        for (int i = 0; i < NRAND; i++) begin
            int r;
            r = $urandom_range(0, 999);
            if (i == 0) cin_q[i] = 1'b1;
            else if (i >= 600 && i < 700) cin_q[i] = !cin_q[i-1];
            else if (r < 8) cin_q[i] = !cin_q[i-1];
            else cin_q[i] = cin_q[i-1];
            rst_q[i] = (i < 2) || (r == 999);
        end
        for (int run = 0; run < 2; run++) begin
            for (int i = 0; i < NRAND; i++) begin
                reset = rst_q[i]; clean_in = cin_q[i];
                tick();
                if (run == 0) trace_q[i] = m_noisy;
                else chk("replay_trace", {31'd0, noisy_a}, {31'd0, trace_q[i]});
                if (i == 699 && !rst_q[i]) chk("chatter_busy", {31'd0, busy_a}, 32'd1);
            end
        end
        reset = 1'b0;
        ticks(BC + 2);
        chk("final_settle", {31'd0, noisy_a}, {31'd0, clean_in});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
Name: bounce_gen

Overview:
- Switch-bounce emulator: converts a clean, synchronous level into a realistic noisy switch waveform.
- Drives debounce-style input conditioners in hardware-in-the-loop and self-test builds, in place of a physical switch.
- Each input edge produces a burst of pseudo-random glitches, then a stable settle at the new level.
- Glitch timing comes from a seeded LFSR, so waveforms are repeatable for a given seed.

Parameters:
- BOUNCE_CYCLES, 2000: length of the bounce window in clock cycles, counted from the triggering edge. Range 1 to 2^20-1.
- MIN_GLITCH, 8: minimum segment length in cycles between noisy_out toggles. Must be at least 1.
- GLITCH_BITS, 4: number of LFSR bits added to MIN_GLITCH for each segment. Segment length = MIN_GLITCH + lfsr[GLITCH_BITS-1:0]. Range 1 to 8.
- SEED, 16'hACE1: LFSR reset value. A value of 0 is replaced internally by 16'hACE1.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high
- clean_in  input  1  clean commanded switch level, synchronous to clock
- noisy_out  output  1  emulated bouncing switch level, registered
- busy  output  1  high while a bounce window is active
- bounce_count  output  8  toggles in current/last event (only with BOUNCE_GEN_STATS_EN)

Behaviour:
- Reset (clock = clock, reset = reset, synchronous, active-high):
  - noisy_out <= clean_in; target <= clean_in; busy <= 0; state <= IDLE.
  - window <= 0; seg <= 0; lfsr <= SEED (or 16'hACE1 if SEED == 0).
  - Reset wins over all other events in the same cycle. Reset mid-bounce aborts immediately; noisy_out snaps to clean_in on the next edge.
- LFSR:
  - 16-bit Galois, right shift, taps 16'hB400.
  - Advances every non-reset cycle in every state. Never reaches 0.
- State IDLE:
  - busy = 0; noisy_out holds target.
  - When clean_in != target: target <= clean_in; noisy_out <= ~noisy_out (first toggle); window <= 0; seg <= MIN_GLITCH + lfsr[GLITCH_BITS-1:0]; state <= BOUNCE.
  - Latency: first noisy_out edge appears 1 cycle after clean_in changes.
- State BOUNCE:
  - busy = 1.
  - window increments by 1 every cycle; seg decrements by 1 every cycle.
  - When seg reaches 1 and window + 1 < BOUNCE_CYCLES: noisy_out <= ~noisy_out; seg reloads from the LFSR.
  - When window + 1 == BOUNCE_CYCLES: noisy_out <= target; state <= IDLE. busy drops on the same edge that noisy_out settles.
  - Because the final value is forced to target, the toggle parity needs no tracking.
- Retrigger:
  - A clean_in change while in BOUNCE does: target <= clean_in; window <= 0; seg reloads. State stays BOUNCE.
  - noisy_out is not forced on that cycle.
- Boundary cases:
  - BOUNCE_CYCLES == 1: a single toggle then settle, so noisy_out equals target 2 cycles after the edge.
  - A segment longer than the remaining window is truncated by the settle.
  - clean_in toggling every cycle keeps busy high indefinitely; noisy_out still toggles only on segment expiry.
- Settle guarantee: noisy_out == clean_in and stable no later than BOUNCE_CYCLES + 1 cycles after the last clean_in change.
- Widths: window is 20 bits; seg is 9 bits. No wrap is possible within the parameter ranges.

Optional Feature:
- Macro: BOUNCE_GEN_STATS_EN.
- Defined:
  - bounce_count port present.
  - Cleared to 0 on reset.
  - Set to 1 on each IDLE->BOUNCE entry or retrigger.
  - Increments on every noisy_out toggle in BOUNCE, including the final settle toggle if it changes the level.
  - Saturates at 255 and holds its value in IDLE.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Test parameters: BOUNCE_CYCLES=100, MIN_GLITCH=4, GLITCH_BITS=3, SEED=16'hACE1.
- Reset with clean_in=1 -> noisy_out=1 and busy=0 on the first post-reset edge; noisy_out stays 1 for 50 idle cycles.
- clean_in 1->0 at cycle T -> noisy_out=0 and busy=1 at T+1. Every inter-toggle gap is 4..11 cycles. noisy_out=0 and busy=0 at T+101, stable thereafter.
- Two runs with identical stimulus and seed -> bit-identical noisy_out traces. SEED=0 gives the same trace as SEED=16'hACE1.
- clean_in 0->1 at T, back 1->0 at T+40 -> window restarts. Final noisy_out=0 and busy low at T+141; no settle at T+101.
- Assert reset at T+30 mid-bounce with clean_in=1 -> noisy_out=1 and busy=0 at T+31. A subsequent edge produces a normal burst.
- With BOUNCE_GEN_STATS_EN and the noisy_out output fed into a debounce instance (DELAY=200) -> bounce_count >= 9 after the event. Debounced output changes exactly once, about 300 cycles after the edge.
